// File: rtl/mult_share_arb.sv
// mult_share_arb
//
// Shares one signed inWidth x inWidth multiplier among four requesters.
// A round-robin arbiter accepts one operand pair per cycle into stage 1.
// Stage 2 holds the sign-extended product and its requester ID. Stage 2
// drives a valid/ready output port.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - asynchronous active-high reset
//   req       - per-requester request, bit i = requester i
//   reqIn0    - operand 0 of requester i in bits [i*inWidth +: inWidth]
//   reqIn1    - operand 1, same packing as reqIn0
//   gnt       - one-hot acceptance (combinational), operands taken at this edge
//   outValid  - product valid
//   outReady  - downstream accepts the product
//   outId     - requester index of the current product
//   out       - signed product, sign-extended to outWidth
//   busy      - either pipeline stage holds data
module mult_share_arb #(
  parameter int unsigned inWidth  = 8,
  parameter int unsigned outWidth = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             req,
  input  logic [4*inWidth-1:0]   reqIn0,
  input  logic [4*inWidth-1:0]   reqIn1,
  output logic [3:0]             gnt,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [1:0]             outId,
  output logic [outWidth-1:0]    out,
  output logic                   busy
);

  if (outWidth < 2 * inWidth) begin : g_width_check
    $error("outWidth must be at least 2*inWidth");
  end

  // Stage 1: operands, id, valid
  logic               v1_q, v1_d;
  logic [inWidth-1:0] in0_q, in0_d;
  logic [inWidth-1:0] in1_q, in1_d;
  logic [1:0]         id1_q, id1_d;
  // Stage 2: product, id, valid
  logic                out_valid_q, out_valid_d;
  logic [1:0]          out_id_q, out_id_d;
  logic [outWidth-1:0] out_q, out_d;
  // Index of the most recent grant
  logic [1:0]          last_q, last_d;

  logic       s2_load;
  logic       s1_load;
  logic       found;
  logic [1:0] cand;
  logic [1:0] gnt_idx;
  logic       grant;

  logic signed [2*inWidth-1:0] a_ext;
  logic signed [2*inWidth-1:0] b_ext;
  logic signed [2*inWidth-1:0] prod;
  logic        [outWidth-1:0]  prod_ext;

  assign s2_load = !out_valid_q || outReady;
  assign s1_load = !v1_q || s2_load;

  // Round-robin search starting one past the last grant.
  // The search wraps around to the last granted index itself.
  always_comb begin
    found   = 1'b0;
    cand    = 2'd0;
    gnt_idx = last_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Reset gating keeps gnt low for the whole reset period.
  // During reset the pipeline would otherwise look empty and able to accept.
  assign grant = found && s1_load && !rst;
  assign gnt   = grant ? (4'b0001 << gnt_idx) : 4'b0000;

  // Size casts of signed values sign-extend, so the full 2*inWidth product is kept.
  assign a_ext    = (2 * inWidth)'($signed(in0_q));
  assign b_ext    = (2 * inWidth)'($signed(in1_q));
  assign prod     = a_ext * b_ext;
  assign prod_ext = outWidth'(prod);

  always_comb begin
    v1_d        = v1_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    id1_d       = id1_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_d       = out_q;

    // When S1 may load, its old contents either moved to S2 or it was empty.
    if (s1_load) begin
      v1_d = grant;
      if (grant) begin
        in0_d  = reqIn0[gnt_idx*inWidth +: inWidth];
        in1_d  = reqIn1[gnt_idx*inWidth +: inWidth];
        id1_d  = gnt_idx;
        last_d = gnt_idx;
      end
    end

    // Result registers only change when real data moves in.
    if (s2_load) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        out_d    = prod_ext;
        out_id_d = id1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      in0_q       <= '0;
      in1_q       <= '0;
      id1_q       <= 2'd0;
      last_q      <= 2'd3;
      out_valid_q <= 1'b0;
      out_id_q    <= 2'd0;
      out_q       <= '0;
    end else begin
      v1_q        <= v1_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      id1_q       <= id1_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_q       <= out_d;
    end
  end

  assign outValid = out_valid_q;
  assign outId    = out_id_q;
  assign out      = out_q;
  assign busy     = v1_q | out_valid_q;

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and two-stage pipeline sequencer that shares one signed `inWidth`×`inWidth` multiplier among four requesters. Each requester presents an operand pair with a request. The block grants one pair per cycle, registers the operands, and forms the sign-extended product. It then delivers the product, tagged with the requester ID, on a valid/ready output port. It sits between the per-channel datapaths and the single shared multiplier resource.

## Interface
- `inWidth`, 8, operand width, signed two's complement.
- `outWidth`, 20, product width. Must satisfy `outWidth` >= 2*`inWidth`. The product is sign-extended to this width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req` input 4: per-requester request; bit i belongs to requester i.
- `reqIn0` input 4*`inWidth`: operand 0 of requester i in bits [i*`inWidth` +: `inWidth`].
- `reqIn1` input 4*`inWidth`: operand 1, same packing as `reqIn0`.
- `gnt` output 4: one-hot acceptance (combinational); bit i high means requester i's operands are taken at this edge.
- `outValid` output 1: product valid.
- `outReady` input 1: downstream accepts the product.
- `outId` output 2: requester index of the current product.
- `out` output `outWidth`: signed product, sign-extended.
- `busy` output 1: high when either pipeline stage holds data.

## Operation
- Requesters hold `req[i]` and their operands stable until `gnt[i]` is seen high at a clock edge. The handshake completes on `req[i]`&&`gnt[i]` at a rising edge.
- Stage 1 (S1) registers: `in0`, `in1` and id, plus valid `v1`. Stage 2 (S2) registers: product, id and `outValid`.
- Advance rules:
  - S2 can load when S2 is empty or `outReady`=1.
  - S1 can load when S1 is empty or S2 can load.
  - `gnt` is all-zero unless S1 can load.
- Arbitration (round-robin):
  - Pointer `last` (2 bits) holds the index of the most recent grant.
  - Search order is `last`+1, `last`+2, `last`+3, `last` (mod 4). The first set `req` bit wins.
  - `last` updates only on a completed grant. With one requester active alone, it is granted every cycle.
- Arithmetic: S2 loads `out` = sign-extend(S1.`in0` × S1.`in1`). The operands are treated as signed; the full 2*`inWidth` result is kept and the upper bits are replicated from bit 2*`inWidth`-1. No truncation and no saturation.
- `outId` and `out` change only when S2 loads.
- While `outValid`=1 and `outReady`=0, `out`/`outId` hold stable.
- S1 holds when it is full and S2 cannot load. Once both stages are full, no grant is issued.
- `busy` = `v1` | `outValid`.
- Reset (asynchronous, at any time, including mid-transfer):
  - `v1`=0, `outValid`=0, `out`=0, `outId`=0, `last`=3 (so requester 0 has highest priority after reset).
  - `gnt`=0 and `busy`=0 while `rst`=1.
  - In-flight operands are discarded; requesters must re-request.

## Timing
- Latency: a grant at edge N gives `outValid`=1 after edge N+1, provided S2 could load at edge N+1. Two-cycle issue-to-result.
- Throughput: one product per cycle with `outReady` held high.
- `gnt` depends combinationally on `req`, `last`, `v1`, `outValid` and `outReady`. It has no combinational path from operand data.
- Simultaneous events:
  - `outReady`=1 with a full S1 and a new grant in the same cycle: S2 takes S1, S1 takes the new pair. No bubble.
  - Deasserting `req[i]` without a grant is legal; nothing is recorded.
- `outReady` high while `outValid`=0 has no effect.

## Test plan
- Single op: at reset release, `req`=0001, in0=-128, in1=127 -> `gnt`=0001 for one cycle. Two cycles later `outValid`=1, `outId`=0, `out`=0xFC080 (-16256).
- Sign cases (req 2): (-128,-128) -> `out`=0x04000. (-1,1) -> 0xFFFFF. (0,-5) -> 0x00000. (127,127) -> 0x03F01.
- Fairness: `req`=1111 held, `outReady`=1 -> `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles. `outId` follows 0,1,2,3,0 two cycles later.
- Backpressure: stream from requester 1, drop `outReady` for 5 cycles -> at most one more grant after the drop (fills S1), then `gnt`=0. `out` is stable, with no loss or duplication on resume.
- Reset mid-op: assert `rst` asynchronously with both stages full -> `outValid`, `busy`, `gnt` go to 0 immediately. After release, `req`=1010 grants requester 1 first.
- Late requester: `req`=0001 continuous, then `req[2]` asserts -> requester 2 is granted within 2 cycles, after which grants alternate 0,2.
